// File: rtl/checkpoint_ring_if.sv
// Port bundle for checkpoint_ring: allocation, update, lookup, retire and recovery signals.
// The ring owns the slave side; the pipeline (or a bench) owns the master side.
interface checkpoint_ring_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PUSH_W = 2,
  parameter int unsigned UPD_W  = 4,
  parameter int unsigned RD_W   = 6,
  parameter int unsigned POP_W  = 4
);
  localparam int unsigned ID_W = $clog2(DEPTH);

  logic [ID_W-1:0]   alloc_id [PUSH_W];
  logic [PUSH_W-1:0] alloc_ready;
  logic [PUSH_W-1:0] push_valid;
  logic [DATA_W-1:0] push_data [PUSH_W];
  logic [ID_W-1:0]   upd_id [UPD_W];
  logic [DATA_W-1:0] upd_data [UPD_W];
  logic [UPD_W-1:0]  upd_we;
  logic [ID_W-1:0]   rd_id [RD_W];
  logic [DATA_W-1:0] rd_data [RD_W];
  logic [RD_W-1:0]   rd_live;
  logic [POP_W-1:0]  pop;
  logic              rollback_valid;
  logic [ID_W-1:0]   rollback_id;
  logic              flush;
  logic [ID_W:0]     count;
  logic              empty;
  logic              full;

  modport master (
    input  alloc_id, alloc_ready, rd_data, rd_live, count, empty, full,
    output push_valid, push_data, upd_id, upd_data, upd_we, rd_id, pop,
           rollback_valid, rollback_id, flush
  );

  modport slave (
    output alloc_id, alloc_ready, rd_data, rd_live, count, empty, full,
    input  push_valid, push_data, upd_id, upd_data, upd_we, rd_id, pop,
           rollback_valid, rollback_id, flush
  );
endinterface

// File: rtl/checkpoint_ring.sv
// Circular branch-checkpoint store with multi-lane allocation, update/lookup ports,
// multi-lane retire, flush and partial rollback to a surviving checkpoint id.
module checkpoint_ring #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PUSH_W = 2,
  parameter int unsigned UPD_W  = 4,
  parameter int unsigned RD_W   = 6,
  parameter int unsigned POP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  checkpoint_ring_if.slave ring
);
  localparam int unsigned ID_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W = ID_W + 1;
  localparam int unsigned SUM_W = 16;

  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [PTR_W-1:0]  count_c;
  logic [PTR_W-1:0]  free_c;
  logic [ID_W-1:0]   alloc_id_c [PUSH_W];
  logic [SUM_W-1:0]  n_push_c;
  logic [SUM_W-1:0]  n_pop_c;
  logic [SUM_W-1:0]  pop_adv_c;
  logic [ID_W-1:0]   rb_dist_c;
  logic              rb_live_c;
  logic              push_ok_c;

  // Occupancy, allocation view and combinational lookups from current state.
  always_comb begin
    count_c = wptr_q - rptr_q;
    free_c  = PTR_W'(DEPTH) - count_c;
    ring.count = count_c;
    ring.empty = (count_c == '0);
    ring.full  = (count_c == PTR_W'(DEPTH));
    for (int unsigned k = 0; k < PUSH_W; k++) begin
      alloc_id_c[k]       = wptr_q[ID_W-1:0] + ID_W'(k);
      ring.alloc_id[k]    = alloc_id_c[k];
      ring.alloc_ready[k] = (SUM_W'(free_c) >= SUM_W'(k + 1));
    end
    for (int unsigned i = 0; i < RD_W; i++) begin
      ring.rd_data[i] = mem_q[ring.rd_id[i]];
      ring.rd_live[i] = (PTR_W'(ID_W'(ring.rd_id[i] - rptr_q[ID_W-1:0])) < count_c);
    end
  end

  // Pointer next-state: flush > rollback > push; pop runs alongside rollback/push.
  always_comb begin
    n_push_c = '0;
    n_pop_c  = '0;
    for (int unsigned k = 0; k < PUSH_W; k++) n_push_c = n_push_c + SUM_W'(ring.push_valid[k]);
    for (int unsigned k = 0; k < POP_W; k++)  n_pop_c  = n_pop_c + SUM_W'(ring.pop[k]);
    pop_adv_c = (n_pop_c < SUM_W'(count_c)) ? n_pop_c : SUM_W'(count_c);
    rb_dist_c = ring.rollback_id - rptr_q[ID_W-1:0];
    rb_live_c = (PTR_W'(rb_dist_c) < count_c);
    push_ok_c = !rst && !ring.flush && !ring.rollback_valid &&
                (n_push_c != '0) && (n_push_c <= SUM_W'(free_c));
    rptr_d = rptr_q + PTR_W'(pop_adv_c);
    wptr_d = wptr_q;
    if (ring.flush) begin
      rptr_d = '0;
      wptr_d = '0;
    end else if (ring.rollback_valid) begin
      if (rb_live_c) wptr_d = rptr_q + PTR_W'(rb_dist_c) + PTR_W'(1);
    end else if (push_ok_c) begin
      wptr_d = wptr_q + PTR_W'(n_push_c);
    end
  end

  // Storage writes: later update ports override earlier ones, accepted push lanes override all.
  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) mem_d[e] = mem_q[e];
    for (int unsigned u = 0; u < UPD_W; u++) begin
      if (ring.upd_we[u]) mem_d[ring.upd_id[u]] = ring.upd_data[u];
    end
    if (push_ok_c) begin
      for (int unsigned k = 0; k < PUSH_W; k++) begin
        if (ring.push_valid[k]) mem_d[alloc_id_c[k]] = ring.push_data[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Protocol checks; over-popping is tolerated (clamped) so it only warns.
  always_ff @(posedge clk) begin
    if (!rst && !ring.flush) begin
      assert (n_pop_c <= SUM_W'(count_c))
        else $warning("checkpoint_ring: pop beyond occupancy ignored");
      if (ring.rollback_valid) begin
        assert (rb_live_c)
          else $error("checkpoint_ring: rollback to non-live id");
        assert (n_pop_c <= SUM_W'(rb_dist_c) + SUM_W'(1))
          else $error("checkpoint_ring: pop past rollback survivor");
      end
    end
  end
endmodule

// File: tb/tb_checkpoint_ring.sv
// Scoreboard bench for checkpoint_ring: a queue/array reference model produces the
// expected post-cycle view, a monitor pops and compares it after every clock edge.
module tb_checkpoint_ring;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned PUSH_W = 2;
  localparam int unsigned UPD_W  = 4;
  localparam int unsigned RD_W   = 6;
  localparam int unsigned POP_W  = 4;

  typedef struct packed {
    logic [4:0]              count;
    logic                    empty;
    logic                    full;
    logic [PUSH_W-1:0][3:0]  aid;
    logic [PUSH_W-1:0]       ardy;
    logic [RD_W-1:0]         live;
    logic [RD_W-1:0]         dchk;
    logic [RD_W-1:0][63:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  checkpoint_ring_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PUSH_W(PUSH_W),
                       .UPD_W(UPD_W), .RD_W(RD_W), .POP_W(POP_W)) ring ();

  checkpoint_ring #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PUSH_W(PUSH_W),
                    .UPD_W(UPD_W), .RD_W(RD_W), .POP_W(POP_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ring (ring)
  );

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: unbounded read/write positions plus a plain storage array.
  int rp = 0;
  int wp = 0;
  logic [63:0] mem_m [DEPTH];
  bit          wr_m  [DEPTH];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic idle();
    ring.push_valid = '0;
    ring.upd_we = '0;
    ring.pop = '0;
    ring.rollback_valid = 1'b0;
    ring.rollback_id = '0;
    ring.flush = 1'b0;
    for (int k = 0; k < PUSH_W; k++) ring.push_data[k] = '0;
    for (int u = 0; u < UPD_W; u++) begin
      ring.upd_id[u] = '0;
      ring.upd_data[u] = '0;
    end
    for (int i = 0; i < RD_W; i++) ring.rd_id[i] = '0;
  endtask

  // Apply current inputs to the model, queue the expected post-edge view, advance one cycle.
  task automatic tick(input bit do_rst);
    exp_t e;
    int cnt, n, m, adv, d, id;
    bit acc;
    for (int i = 1; i < RD_W; i++) ring.rd_id[i] = 4'($urandom_range(0, DEPTH - 1));
    cnt = wp - rp;
    n = 0;
    m = 0;
    for (int k = 0; k < PUSH_W; k++) n += int'(ring.push_valid[k]);
    for (int k = 0; k < POP_W; k++)  m += int'(ring.pop[k]);
    if (do_rst) begin
      rp = 0;
      wp = 0;
    end else begin
      for (int u = 0; u < UPD_W; u++) begin
        if (ring.upd_we[u]) begin
          mem_m[ring.upd_id[u]] = ring.upd_data[u];
          wr_m[ring.upd_id[u]] = 1'b1;
        end
      end
      acc = !ring.flush && !ring.rollback_valid && n > 0 && n <= int'(DEPTH) - cnt;
      if (acc) begin
        for (int k = 0; k < n; k++) begin
          mem_m[(wp + k) % DEPTH] = ring.push_data[k];
          wr_m[(wp + k) % DEPTH] = 1'b1;
        end
      end
      adv = (m < cnt) ? m : cnt;
      if (ring.flush) begin
        rp = 0;
        wp = 0;
      end else begin
        if (ring.rollback_valid) begin
          d = (int'(ring.rollback_id) - rp % DEPTH + DEPTH) % DEPTH;
          if (d < cnt) wp = rp + d + 1;
        end else if (acc) begin
          wp = wp + n;
        end
        rp = rp + adv;
      end
    end
    cnt = wp - rp;
    e.count = 5'(cnt);
    e.empty = (cnt == 0);
    e.full  = (cnt == DEPTH);
    for (int k = 0; k < PUSH_W; k++) begin
      e.aid[k]  = 4'((wp + k) % DEPTH);
      e.ardy[k] = (int'(DEPTH) - cnt) >= k + 1;
    end
    for (int i = 0; i < RD_W; i++) begin
      id = int'(ring.rd_id[i]);
      e.live[i] = ((id - rp % DEPTH + DEPTH) % DEPTH) < cnt;
      e.dchk[i] = wr_m[id];
      e.data[i] = mem_m[id];
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic push_n(input int cycles, input logic [1:0] pv);
    repeat (cycles) begin
      idle();
      ring.push_valid = pv;
      for (int k = 0; k < PUSH_W; k++) ring.push_data[k] = 64'(wp + k);
      tick(0);
    end
  endtask

  task automatic do_flush();
    idle();
    ring.flush = 1'b1;
    tick(0);
  endtask

  // Monitor: compare the DUT against each queued expectation just after the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        cmp("count", 64'(ring.count), 64'(mon_e.count));
        cmp("empty", 64'(ring.empty), 64'(mon_e.empty));
        cmp("full", 64'(ring.full), 64'(mon_e.full));
        cmp("alloc_ready", 64'(ring.alloc_ready), 64'(mon_e.ardy));
        for (int k = 0; k < PUSH_W; k++)
          cmp($sformatf("alloc_id%0d", k), 64'(ring.alloc_id[k]), 64'(mon_e.aid[k]));
        cmp("rd_live", 64'(ring.rd_live), 64'(mon_e.live));
        for (int i = 0; i < RD_W; i++) begin
          if (mon_e.dchk[i])
            cmp($sformatf("rd_data%0d", i), ring.rd_data[i], mon_e.data[i]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, d, m, r, lim;
    idle();
    rst = 1'b1;
    @(negedge clk);
    tick(1);
    rst = 1'b0;
    cmp("rst_count", 64'(ring.count), 64'd0);
    cmp("rst_empty", 64'(ring.empty), 64'd1);
    cmp("rst_alloc_ready", 64'(ring.alloc_ready), 64'b11);
    cmp("rst_alloc_id1", 64'(ring.alloc_id[1]), 64'd1);

    // Fill completely, then an extra request must be dropped.
    push_n(8, 2'b11);
    cmp("fill_count", 64'(ring.count), 64'd16);
    cmp("fill_full", 64'(ring.full), 64'd1);
    cmp("fill_alloc_ready", 64'(ring.alloc_ready), 64'b00);
    push_n(1, 2'b11);
    cmp("overfill_count", 64'(ring.count), 64'd16);
    cmp("overfill_alloc_id0", 64'(ring.alloc_id[0]), 64'd0);

    // From 15 live: two-lane push rejected, one-lane push accepted.
    idle();
    ring.pop = 4'b0001;
    tick(0);
    push_n(1, 2'b11);
    cmp("reject2_count", 64'(ring.count), 64'd15);
    push_n(1, 2'b01);
    cmp("accept1_count", 64'(ring.count), 64'd16);

    // Partial rollback to id 4 out of ids 0..9.
    do_flush();
    push_n(5, 2'b11);
    idle();
    ring.rollback_valid = 1'b1;
    ring.rollback_id = 4'd4;
    ring.rd_id[0] = 4'd7;
    tick(0);
    cmp("rb_count", 64'(ring.count), 64'd5);
    cmp("rb_alloc_id0", 64'(ring.alloc_id[0]), 64'd5);
    cmp("rb_live7", 64'(ring.rd_live[0]), 64'd0);
    idle();
    ring.push_valid = 2'b01;
    ring.push_data[0] = 64'h5555;
    ring.rd_id[0] = 4'd5;
    tick(0);
    cmp("rb_push_id5", ring.rd_data[0], 64'h5555);

    // Wrap-around: push 14, pop 12, push 10.
    do_flush();
    push_n(7, 2'b11);
    idle();
    ring.pop = 4'b1111;
    repeat (3) tick(0);
    push_n(5, 2'b11);
    idle();
    ring.rd_id[0] = 4'd1;
    tick(0);
    cmp("wrap_count", 64'(ring.count), 64'd12);
    cmp("wrap_id1_data", ring.rd_data[0], 64'd17);
    cmp("wrap_id1_live", 64'(ring.rd_live[0]), 64'd1);

    // Write arbitration on id 2: push beats updates, then highest update port wins.
    do_flush();
    push_n(2, 2'b01);
    idle();
    ring.upd_we = 4'b1010;
    ring.upd_id[1] = 4'd2;
    ring.upd_id[3] = 4'd2;
    ring.upd_data[1] = 64'hAAAA;
    ring.upd_data[3] = 64'hBBBB;
    ring.push_valid = 2'b01;
    ring.push_data[0] = 64'hCCCC;
    ring.rd_id[0] = 4'd2;
    tick(0);
    cmp("arb_push_wins", ring.rd_data[0], 64'hCCCC);
    idle();
    ring.upd_we = 4'b1010;
    ring.upd_id[1] = 4'd2;
    ring.upd_id[3] = 4'd2;
    ring.upd_data[1] = 64'hDDDD;
    ring.upd_data[3] = 64'hEEEE;
    ring.rd_id[0] = 4'd2;
    tick(0);
    cmp("arb_port3_wins", ring.rd_data[0], 64'hEEEE);

    // Flush dominates push and rollback; popping an empty ring does nothing.
    idle();
    ring.flush = 1'b1;
    ring.push_valid = 2'b11;
    ring.rollback_valid = 1'b1;
    ring.rollback_id = 4'd1;
    tick(0);
    cmp("flush_count", 64'(ring.count), 64'd0);
    cmp("flush_alloc_id0", 64'(ring.alloc_id[0]), 64'd0);
    idle();
    ring.pop = 4'b0001;
    tick(0);
    cmp("pop_empty_count", 64'(ring.count), 64'd0);
    cmp("pop_empty_alloc_id0", 64'(ring.alloc_id[0]), 64'd0);

    // Randomized legal traffic.
    repeat (400) begin
      idle();
      cnt = wp - rp;
      r = $urandom_range(0, 99);
      m = 0;
      if (r < 3) begin
        ring.flush = 1'b1;
      end else if (r < 13 && cnt > 0) begin
        d = $urandom_range(0, cnt - 1);
        ring.rollback_valid = 1'b1;
        ring.rollback_id = 4'((rp + d) % DEPTH);
        lim = (d + 1 < cnt) ? d + 1 : cnt;
        if (lim > 4) lim = 4;
        m = $urandom_range(0, lim);
      end else begin
        lim = (cnt < 4) ? cnt : 4;
        m = (r < 60) ? $urandom_range(0, lim) : 0;
      end
      ring.pop = 4'((1 << m) - 1);
      case ($urandom_range(0, 2))
        0:       ring.push_valid = 2'b00;
        1:       ring.push_valid = 2'b01;
        default: ring.push_valid = 2'b11;
      endcase
      for (int k = 0; k < PUSH_W; k++) ring.push_data[k] = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ring.upd_we = 4'($urandom_range(0, 15));
      for (int u = 0; u < UPD_W; u++) begin
        ring.upd_id[u] = 4'($urandom_range(0, DEPTH - 1));
        ring.upd_data[u] = {$urandom, $urandom};
      end
      ring.rd_id[0] = (cnt > 0) ? 4'((rp + $urandom_range(0, cnt - 1)) % DEPTH)
                                : 4'($urandom_range(0, DEPTH - 1));
      tick(0);
    end

    idle();
    @(negedge clk);
    @(negedge clk);
    cmp("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
